// File: rtl/config_loader.sv
// Configuration-chain loader: clears the tile chain, then serialises upstream
// bitstream words LSB first onto cfg_data/cfg_enable until CHAIN_BITS are shifted.
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_BITS   = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  cfg_data,
  output logic                  cfg_enable,
  output logic                  cfg_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(CHAIN_BITS + 1);
  localparam int RW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] CHAIN_TOTAL = CW'(CHAIN_BITS);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t                state, state_n;
  logic [WORD_WIDTH-1:0] sh, sh_n;
  logic [RW-1:0]         rem, rem_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [KW-1:0]         clr, clr_n;
  logic [CW-1:0]         left;
  logic [RW-1:0]         last_idx;
  logic                  in_ready_n, cfg_data_n, cfg_enable_n, cfg_nreset_n;

  // cnt counts bits presented up to and including the current cycle; rem is the
  // number of holding-register bits still to follow the one on cfg_data now.
  // Outputs are registered from next-state values so they describe that cycle.
  always_comb begin
    state_n      = state;
    sh_n         = sh;
    rem_n        = rem;
    cnt_n        = cnt;
    clr_n        = clr;
    cfg_data_n   = 1'b0;
    cfg_enable_n = 1'b0;
    cfg_nreset_n = 1'b1;
    left         = CHAIN_TOTAL - cnt;
    if (int'(left) < WORD_WIDTH)
      last_idx = RW'(left - CW'(1));
    else
      last_idx = RW'(WORD_WIDTH - 1);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = CLEAR;
          clr_n        = '0;
          cnt_n        = '0;
          rem_n        = '0;
          sh_n         = '0;
          cfg_nreset_n = 1'b0;
        end
      end
      CLEAR: begin
        if (clr == KW'(CLEAR_CYCLES - 1)) begin
          state_n = SHIFT;
        end else begin
          clr_n        = clr + KW'(1);
          cfg_nreset_n = 1'b0;
        end
      end
      SHIFT: begin
        if (cfg_enable && cnt == CHAIN_TOTAL) begin
          state_n = DONE;
        end else if (in_ready && in_valid) begin
          cfg_enable_n = 1'b1;
          cfg_data_n   = in_data[0];
          sh_n         = in_data >> 1;
          rem_n        = last_idx;
          cnt_n        = cnt + CW'(1);
        end else if (rem != '0) begin
          cfg_enable_n = 1'b1;
          cfg_data_n   = sh[0];
          sh_n         = sh >> 1;
          rem_n        = rem - RW'(1);
          cnt_n        = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (abort) begin
      state_n      = IDLE;
      sh_n         = '0;
      rem_n        = '0;
      cnt_n        = '0;
      clr_n        = '0;
      cfg_data_n   = 1'b0;
      cfg_enable_n = 1'b0;
      cfg_nreset_n = 1'b1;
    end

    in_ready_n = (state_n == SHIFT) && (rem_n == '0) && (cnt_n < CHAIN_TOTAL);
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state      <= IDLE;
      sh         <= '0;
      rem        <= '0;
      cnt        <= '0;
      clr        <= '0;
      in_ready   <= 1'b0;
      cfg_data   <= 1'b0;
      cfg_enable <= 1'b0;
      cfg_nreset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      rem        <= rem_n;
      cnt        <= cnt_n;
      clr        <= clr_n;
      in_ready   <= in_ready_n;
      cfg_data   <= cfg_data_n;
      cfg_enable <= cfg_enable_n;
      cfg_nreset <= cfg_nreset_n;
      busy       <= (state_n == CLEAR) || (state_n == SHIFT);
      done       <= (state_n == DONE);
    end
  end

endmodule
